uart_rx_fifo_bridge: RTL

AXI4-Lite bridge between the MMU and the AXI UART Lite that drains received bytes into a parametrised in-order FIFO whenever the bus is idle. Reads from RX offset 0x0 are served from the FIFO. Other reads are forwarded. The write path is a combinational pass-through. It replaces the single-stack RX buffer with true FIFO ordering, configurable depth, full back-pressure and status merging.

---
 rtl/uart_rx_fifo_bridge.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_bridge.sv
// AXI4-Lite bridge that drains UART Lite RX bytes into an in-order FIFO while the bus is idle.
// Optional macro UART_RX_FIFO_STATUS_EN merges FIFO state into forwarded STAT (0x8) reads.
module uart_rx_fifo_bridge #(
   parameter int DEPTH_LOG2 = 11,
   parameter int POLL_GAP   = 0
) (
   input  logic                  clk,
   input  logic                  rstn,
   // MMU read channels
   input  logic [3:0]            mmu_axi_araddr,
   input  logic [2:0]            mmu_axi_arprot,
   input  logic                  mmu_axi_arvalid,
   output logic                  mmu_axi_arready,
   output logic [31:0]           mmu_axi_rdata,
   output logic [1:0]            mmu_axi_rresp,
   output logic                  mmu_axi_rvalid,
   input  logic                  mmu_axi_rready,
   // MMU write channels
   input  logic [3:0]            mmu_axi_awaddr,
   input  logic [2:0]            mmu_axi_awprot,
   input  logic                  mmu_axi_awvalid,
   output logic                  mmu_axi_awready,
   input  logic [31:0]           mmu_axi_wdata,
   input  logic [3:0]            mmu_axi_wstrb,
   input  logic                  mmu_axi_wvalid,
   output logic                  mmu_axi_wready,
   output logic [1:0]            mmu_axi_bresp,
   output logic                  mmu_axi_bvalid,
   input  logic                  mmu_axi_bready,
   // UART Lite read channels
   output logic [3:0]            uart_axi_araddr,
   output logic [2:0]            uart_axi_arprot,
   output logic                  uart_axi_arvalid,
   input  logic                  uart_axi_arready,
   input  logic [31:0]           uart_axi_rdata,
   input  logic [1:0]            uart_axi_rresp,
   input  logic                  uart_axi_rvalid,
   output logic                  uart_axi_rready,
   // UART Lite write channels
   output logic [3:0]            uart_axi_awaddr,
   output logic [2:0]            uart_axi_awprot,
   output logic                  uart_axi_awvalid,
   input  logic                  uart_axi_awready,
   output logic [31:0]           uart_axi_wdata,
   output logic [3:0]            uart_axi_wstrb,
   output logic                  uart_axi_wvalid,
   input  logic                  uart_axi_wready,
   input  logic [1:0]            uart_axi_bresp,
   input  logic                  uart_axi_bvalid,
   output logic                  uart_axi_bready,
   // Debug
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic [3:0]            fsm_state
);

   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam int         CW        = DEPTH_LOG2 + 1;
   localparam int         GW        = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [3:0] ADDR_RX   = 4'h0;
   localparam logic [3:0] ADDR_STAT = 4'h8;

   typedef enum logic [3:0] {
      IDLE, GAP, POLL_AR, POLL_R, DATA_AR, DATA_R, FWD_AR, FWD_R, RESP
   } state_t;

   state_t                state, state_n;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  empty, full, push, pop;
   logic [GW-1:0]         gap_cnt, gap_cnt_n;
   logic [3:0]            lat_addr, lat_addr_n;
   logic [2:0]            lat_prot, lat_prot_n;
   logic [31:0]           rdata_q, rdata_n, fwd_rdata;
   logic [1:0]            rresp_q, rresp_n;
   logic                  rvalid_q, rvalid_n;
   logic                  arready_q, u_arvalid_q, u_rready_q;
   logic [3:0]            u_araddr_q, u_araddr_n;
   logic [2:0]            u_arprot_q, u_arprot_n;

   // Write path is a plain wire-through; the bridge never owns a write transaction.
   assign uart_axi_awaddr  = mmu_axi_awaddr;
   assign uart_axi_awprot  = mmu_axi_awprot;
   assign uart_axi_awvalid = mmu_axi_awvalid;
   assign uart_axi_wdata   = mmu_axi_wdata;
   assign uart_axi_wstrb   = mmu_axi_wstrb;
   assign uart_axi_wvalid  = mmu_axi_wvalid;
   assign uart_axi_bready  = mmu_axi_bready;
   assign mmu_axi_awready  = uart_axi_awready;
   assign mmu_axi_wready   = uart_axi_wready;
   assign mmu_axi_bresp    = uart_axi_bresp;
   assign mmu_axi_bvalid   = uart_axi_bvalid;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Handshakes: a transfer happens on an edge where valid && ready are both high;
   // a source holds valid and its payload unchanged until that edge.
   assign mmu_axi_arready  = arready_q;
   assign mmu_axi_rdata    = rdata_q;
   assign mmu_axi_rresp    = rresp_q;
   assign mmu_axi_rvalid   = rvalid_q;
   assign uart_axi_araddr  = u_araddr_q;
   assign uart_axi_arprot  = u_arprot_q;
   assign uart_axi_arvalid = u_arvalid_q;
   assign uart_axi_rready  = u_rready_q;
   assign fifo_count       = count;
   assign fsm_state        = state;

   always_comb begin
      fwd_rdata = uart_axi_rdata;
`ifdef UART_RX_FIFO_STATUS_EN
      // Bytes already buffered here must still look like RX-valid to software.
      if (lat_addr == ADDR_STAT) begin
         fwd_rdata[0] = uart_axi_rdata[0] | ~empty;
         fwd_rdata[1] = uart_axi_rdata[1] | full;
      end
`endif
   end

   always_comb begin
      state_n    = state;
      gap_cnt_n  = gap_cnt;
      lat_addr_n = lat_addr;
      lat_prot_n = lat_prot;
      rdata_n    = rdata_q;
      rresp_n    = rresp_q;
      rvalid_n   = rvalid_q;
      push       = 1'b0;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (mmu_axi_arvalid) begin
               lat_addr_n = mmu_axi_araddr;
               lat_prot_n = mmu_axi_arprot;
               if (mmu_axi_araddr == ADDR_RX && !empty) begin
                  pop      = 1'b1;
                  rdata_n  = {24'b0, mem[rd_ptr]};
                  rresp_n  = RESP_OKAY;
                  rvalid_n = 1'b1;
                  state_n  = RESP;
               end else begin
                  state_n = FWD_AR;
               end
            end else if (!full) begin
               gap_cnt_n = '0;
               if (POLL_GAP > 0) state_n = GAP;
               else              state_n = POLL_AR;
            end
         end
         GAP: begin
            if (mmu_axi_arvalid)                     state_n = IDLE;
            else if (gap_cnt == GW'(POLL_GAP - 1))   state_n = POLL_AR;
            else                                     gap_cnt_n = gap_cnt + GW'(1);
         end
         POLL_AR: if (uart_axi_arready) state_n = POLL_R;
         POLL_R: begin
            if (uart_axi_rvalid) begin
               if (uart_axi_rresp == RESP_OKAY && uart_axi_rdata[0]) state_n = DATA_AR;
               else                                                   state_n = IDLE;
            end
         end
         DATA_AR: if (uart_axi_arready) state_n = DATA_R;
         DATA_R: begin
            if (uart_axi_rvalid) begin
               push    = (uart_axi_rresp == RESP_OKAY) && !full;
               state_n = IDLE;
            end
         end
         FWD_AR: if (uart_axi_arready) state_n = FWD_R;
         FWD_R: begin
            if (uart_axi_rvalid) begin
               rdata_n  = fwd_rdata;
               rresp_n  = uart_axi_rresp;
               rvalid_n = 1'b1;
               state_n  = RESP;
            end
         end
         RESP: begin
            if (mmu_axi_rready) begin
               rvalid_n = 1'b0;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // UART address is loaded on entry to an AR state and held until its handshake.
   always_comb begin
      u_araddr_n = u_araddr_q;
      u_arprot_n = u_arprot_q;
      case (state_n)
         POLL_AR: begin u_araddr_n = ADDR_STAT;  u_arprot_n = 3'b000;     end
         DATA_AR: begin u_araddr_n = ADDR_RX;    u_arprot_n = 3'b000;     end
         FWD_AR:  begin u_araddr_n = lat_addr_n; u_arprot_n = lat_prot_n; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         gap_cnt     <= '0;
         lat_addr    <= '0;
         lat_prot    <= '0;
         rdata_q     <= '0;
         rresp_q     <= '0;
         rvalid_q    <= 1'b0;
         arready_q   <= 1'b1;
         u_arvalid_q <= 1'b0;
         u_rready_q  <= 1'b0;
         u_araddr_q  <= '0;
         u_arprot_q  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else begin
         state       <= state_n;
         gap_cnt     <= gap_cnt_n;
         lat_addr    <= lat_addr_n;
         lat_prot    <= lat_prot_n;
         rdata_q     <= rdata_n;
         rresp_q     <= rresp_n;
         rvalid_q    <= rvalid_n;
         arready_q   <= (state_n == IDLE);
         u_arvalid_q <= (state_n == POLL_AR) || (state_n == DATA_AR) || (state_n == FWD_AR);
         u_rready_q  <= (state_n == POLL_R) || (state_n == DATA_R) || (state_n == FWD_R);
         u_araddr_q  <= u_araddr_n;
         u_arprot_q  <= u_arprot_n;
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= uart_axi_rdata[7:0];
   end

endmodule
